lh_ingress_buf: RTL and testbench

//  Store-and-forward packet-header buffer directly downstream of the ingress rate limiter (IRL).

---
 rtl/lh_ingress_buf_pkg.sv | 22 ++
 rtl/lh_ingress_ram.sv | 20 ++
 rtl/lh_ingress_buf.sv | 174 +++++++++++++++++
 tb/tb_lh_ingress_buf.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lh_ingress_buf_pkg.sv
// Shared types for the LH ingress buffer: the per-packet meta from the IRL,
// the stored header beat and the write-side FSM states.
package meta_package;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic [7:0] src_port;
      logic [7:0] flow_id;
   } irl_lh_meta_type;
endpackage

package lh_package;
   import meta_package::*;

   typedef enum logic [1:0] {IDLE, ACCEPT, DROP} lh_ingress_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] hdr;
      logic              sop;
      logic              eop;
   } lh_beat_t;
endpackage

// File: rtl/lh_ingress_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module lh_ingress_ram #(
   parameter int AW = 6,
   parameter int W  = 8
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lh_ingress_buf.sv
// Store-and-forward header buffer behind the ingress rate limiter: packets are
// written speculatively, rewound on overflow/framing errors, and released only once committed.
module lh_ingress_buf
   import meta_package::*;
   import lh_package::*;
#(
   parameter int DEPTH_NBITS      = 6,
   parameter int META_DEPTH_NBITS = 4,
   parameter int MAX_PKT_BEATS    = 8,
   parameter int CNT_NBITS        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 irl_lh_valid,
   input  logic [DATA_W-1:0]    irl_lh_hdr_data,
   input  irl_lh_meta_type      irl_lh_meta_data,
   input  logic                 irl_lh_sop,
   input  logic                 irl_lh_eop,
   output logic                 lh_valid,
   input  logic                 lh_ready,
   output logic [DATA_W-1:0]    lh_hdr_data,
   output irl_lh_meta_type      lh_meta_data,
   output logic                 lh_sop,
   output logic                 lh_eop,
   output logic [CNT_NBITS-1:0] stat_pkt_in,
   output logic [CNT_NBITS-1:0] stat_pkt_drop_ovf,
   output logic [CNT_NBITS-1:0] stat_pkt_drop_err
);
   localparam int PW  = DEPTH_NBITS + 1;
   localparam int MW  = META_DEPTH_NBITS + 1;
   localparam int BCW = $clog2(MAX_PKT_BEATS + 2);
   localparam logic [PW-1:0] ADMIT_LIMIT = PW'(2**DEPTH_NBITS - MAX_PKT_BEATS);
   localparam logic [MW-1:0] META_CAP    = MW'(2**META_DEPTH_NBITS);

   lh_ingress_state_e state_q, state_d;
   logic [PW-1:0]  wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_q, rd_d;
   logic [MW-1:0]  meta_wr_q, meta_wr_d, meta_rd_q, meta_rd_d;
   logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_NBITS-1:0] pkt_in_q, drop_ovf_q, drop_err_q;

   logic inc_in, inc_ovf, inc_err, beat_we, meta_we, admit_ok, rd_fire;
   logic [DEPTH_NBITS-1:0]      beat_waddr;
   logic [META_DEPTH_NBITS-1:0] meta_waddr;
   logic [PW-1:0] used;
   logic [MW-1:0] meta_base, meta_used;
   lh_beat_t wr_beat, rd_beat;

   // A sop arriving in ACCEPT abandons the speculative packet first, so space
   // and meta occupancy are judged as if that packet had already been rewound.
   assign used      = wr_commit_q - rd_q;
   assign meta_base = (state_q == ACCEPT) ? meta_wr_q - MW'(1) : meta_wr_q;
   assign meta_used = meta_base - meta_rd_q;
   assign admit_ok  = (used <= ADMIT_LIMIT) && (meta_used < META_CAP);
   assign wr_beat   = '{hdr: irl_lh_hdr_data, sop: irl_lh_sop, eop: irl_lh_eop};

   always_comb begin
      state_d     = state_q;
      wr_spec_d   = wr_spec_q;
      wr_commit_d = wr_commit_q;
      meta_wr_d   = meta_wr_q;
      beat_cnt_d  = beat_cnt_q;
      inc_in      = 1'b0;
      inc_ovf     = 1'b0;
      inc_err     = 1'b0;
      beat_we     = 1'b0;
      beat_waddr  = wr_spec_q[DEPTH_NBITS-1:0];
      meta_we     = 1'b0;
      meta_waddr  = meta_base[META_DEPTH_NBITS-1:0];
      if (irl_lh_valid) begin
         if (irl_lh_sop) begin
            if (state_q == ACCEPT) inc_err = 1'b1;
            wr_spec_d = wr_commit_q;
            meta_wr_d = meta_base;
            if (admit_ok) begin
               beat_we    = 1'b1;
               beat_waddr = wr_commit_q[DEPTH_NBITS-1:0];
               meta_we    = 1'b1;
               meta_wr_d  = meta_base + MW'(1);
               wr_spec_d  = wr_commit_q + PW'(1);
               beat_cnt_d = BCW'(1);
               state_d    = ACCEPT;
               if (irl_lh_eop) begin
                  wr_commit_d = wr_commit_q + PW'(1);
                  inc_in      = 1'b1;
                  state_d     = IDLE;
               end
            end else begin
               inc_ovf = 1'b1;
               state_d = DROP;
            end
         end else begin
            case (state_q)
               IDLE: inc_err = 1'b1;
               ACCEPT: begin
                  if (beat_cnt_q >= BCW'(MAX_PKT_BEATS)) begin
                     inc_err   = 1'b1;
                     wr_spec_d = wr_commit_q;
                     meta_wr_d = meta_base;
                     state_d   = DROP;
                  end else begin
                     beat_we    = 1'b1;
                     wr_spec_d  = wr_spec_q + PW'(1);
                     beat_cnt_d = beat_cnt_q + BCW'(1);
                     if (irl_lh_eop) begin
                        wr_commit_d = wr_spec_q + PW'(1);
                        inc_in      = 1'b1;
                        state_d     = IDLE;
                     end
                  end
               end
               DROP: if (irl_lh_eop) state_d = IDLE;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   assign lh_valid     = (rd_q != wr_commit_q);
   assign rd_fire      = lh_valid && lh_ready;
   assign rd_d         = rd_fire ? rd_q + PW'(1) : rd_q;
   assign meta_rd_d    = (rd_fire && rd_beat.eop) ? meta_rd_q + MW'(1) : meta_rd_q;
   assign lh_hdr_data  = rd_beat.hdr;
   assign lh_sop       = lh_valid && rd_beat.sop;
   assign lh_eop       = lh_valid && rd_beat.eop;

   // Statistics saturate at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         rd_q        <= '0;
         meta_wr_q   <= '0;
         meta_rd_q   <= '0;
         beat_cnt_q  <= '0;
         pkt_in_q    <= '0;
         drop_ovf_q  <= '0;
         drop_err_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_spec_q   <= wr_spec_d;
         wr_commit_q <= wr_commit_d;
         rd_q        <= rd_d;
         meta_wr_q   <= meta_wr_d;
         meta_rd_q   <= meta_rd_d;
         beat_cnt_q  <= beat_cnt_d;
         if (inc_in  && !(&pkt_in_q))   pkt_in_q   <= pkt_in_q + CNT_NBITS'(1);
         if (inc_ovf && !(&drop_ovf_q)) drop_ovf_q <= drop_ovf_q + CNT_NBITS'(1);
         if (inc_err && !(&drop_err_q)) drop_err_q <= drop_err_q + CNT_NBITS'(1);
      end
   end

   assign stat_pkt_in       = pkt_in_q;
   assign stat_pkt_drop_ovf = drop_ovf_q;
   assign stat_pkt_drop_err = drop_err_q;

   lh_ingress_ram #(.AW(DEPTH_NBITS), .W($bits(lh_beat_t))) u_beat_ram (
      .clk     (clk),
      .we_i    (beat_we),
      .waddr_i (beat_waddr),
      .wdata_i (wr_beat),
      .raddr_i (rd_q[DEPTH_NBITS-1:0]),
      .rdata_o (rd_beat)
   );

   lh_ingress_ram #(.AW(META_DEPTH_NBITS), .W($bits(irl_lh_meta_type))) u_meta_ram (
      .clk     (clk),
      .we_i    (meta_we),
      .waddr_i (meta_waddr),
      .wdata_i (irl_lh_meta_data),
      .raddr_i (meta_rd_q[META_DEPTH_NBITS-1:0]),
      .rdata_o (lh_meta_data)
   );
endmodule

// File: tb/tb_lh_ingress_buf.sv
// Randomized bench for lh_ingress_buf against a packet-level reference model
// (queues of committed beats, occupancy counts and expected statistics).
module tb_lh_ingress_buf;
   import meta_package::*;
   import lh_package::*;

   localparam int BUF_BEATS = 64;
   localparam int META_PKTS = 16;
   localparam int MAX_BEATS = 8;
   localparam int CNT_MAX   = 65535;

   logic clk = 1'b0;
   logic rst;
   logic irl_lh_valid, irl_lh_sop, irl_lh_eop, lh_ready;
   logic [DATA_W-1:0] irl_lh_hdr_data, lh_hdr_data;
   irl_lh_meta_type irl_lh_meta_data, lh_meta_data;
   logic lh_valid, lh_sop, lh_eop;
   logic [15:0] stat_pkt_in, stat_pkt_drop_ovf, stat_pkt_drop_err;

   always #5 clk = ~clk;

   lh_ingress_buf dut (
      .clk               (clk),
      .rst               (rst),
      .irl_lh_valid      (irl_lh_valid),
      .irl_lh_hdr_data   (irl_lh_hdr_data),
      .irl_lh_meta_data  (irl_lh_meta_data),
      .irl_lh_sop        (irl_lh_sop),
      .irl_lh_eop        (irl_lh_eop),
      .lh_valid          (lh_valid),
      .lh_ready          (lh_ready),
      .lh_hdr_data       (lh_hdr_data),
      .lh_meta_data      (lh_meta_data),
      .lh_sop            (lh_sop),
      .lh_eop            (lh_eop),
      .stat_pkt_in       (stat_pkt_in),
      .stat_pkt_drop_ovf (stat_pkt_drop_ovf),
      .stat_pkt_drop_err (stat_pkt_drop_err)
   );

   typedef struct {
      logic [DATA_W-1:0] hdr;
      logic              sop;
      logic              eop;
      irl_lh_meta_type   meta;
   } mbeat_t;

   mbeat_t outQ[$];
   mbeat_t curPkt[$];
   bit collecting, dropping;
   int resBeats, resPkts, expIn, expOvf, expErr;
   int numCompared, numMismatched;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      numCompared++;
      if (obs !== exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic checkAll();
      checkOutput("lh_valid", 64'(lh_valid), 64'(outQ.size() != 0));
      if (outQ.size() != 0) begin
         checkOutput("lh_hdr_data", 64'(lh_hdr_data), 64'(outQ[0].hdr));
         checkOutput("lh_sop", 64'(lh_sop), 64'(outQ[0].sop));
         checkOutput("lh_eop", 64'(lh_eop), 64'(outQ[0].eop));
         checkOutput("lh_meta_data", 64'(lh_meta_data), 64'(outQ[0].meta));
      end
      checkOutput("stat_pkt_in", 64'(stat_pkt_in), 64'(sat(expIn)));
      checkOutput("stat_pkt_drop_ovf", 64'(stat_pkt_drop_ovf), 64'(sat(expOvf)));
      checkOutput("stat_pkt_drop_err", 64'(stat_pkt_drop_err), 64'(sat(expErr)));
   endtask

   task automatic commitPkt();
      foreach (curPkt[i]) outQ.push_back(curPkt[i]);
      resBeats += curPkt.size();
      resPkts++;
      expIn++;
      curPkt.delete();
      collecting = 0;
   endtask

   // Packet-level rules: a sop is admitted only if a max-size packet fits and a
   // meta slot is free; broken or over-long packets vanish without a trace.
   task automatic modelBeat(input mbeat_t b);
      if (b.sop) begin
         if (collecting) begin
            expErr++;
            curPkt.delete();
         end
         collecting = 0;
         dropping   = 0;
         if ((BUF_BEATS - resBeats) >= MAX_BEATS && resPkts < META_PKTS) begin
            curPkt.push_back(b);
            collecting = 1;
            if (b.eop) commitPkt();
         end else begin
            expOvf++;
            dropping = 1;
         end
      end else if (collecting) begin
         if (curPkt.size() >= MAX_BEATS) begin
            expErr++;
            curPkt.delete();
            collecting = 0;
            dropping   = 1;
         end else begin
            b.meta = curPkt[0].meta;
            curPkt.push_back(b);
            if (b.eop) commitPkt();
         end
      end else if (dropping) begin
         if (b.eop) dropping = 0;
      end else begin
         expErr++;
      end
   endtask

   task automatic applyStimulus(input bit v, input bit sop, input bit eop, input bit rdy);
      mbeat_t b;
      bit doPop;
      logic [31:0] r;
      r = $urandom;
      b.hdr  = {$urandom, $urandom};
      b.sop  = sop;
      b.eop  = eop;
      b.meta = r[15:0];
      irl_lh_valid     = v;
      irl_lh_sop       = sop;
      irl_lh_eop       = eop;
      irl_lh_hdr_data  = b.hdr;
      irl_lh_meta_data = b.meta;
      lh_ready         = rdy;
      @(negedge clk);
      checkAll();
      doPop = rdy && (outQ.size() != 0);
      if (v) modelBeat(b);
      if (doPop) begin
         resBeats--;
         if (outQ[0].eop) resPkts--;
         void'(outQ.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sendPkt(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, i == 0, i == n - 1, rdy);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rdy);
   endtask

   task automatic applyReset();
      rst          = 1'b1;
      irl_lh_valid = 1'b0;
      irl_lh_sop   = 1'b0;
      irl_lh_eop   = 1'b0;
      lh_ready     = 1'b0;
      outQ.delete();
      curPkt.delete();
      collecting = 0;
      dropping   = 0;
      resBeats = 0; resPkts = 0; expIn = 0; expOvf = 0; expErr = 0;
      @(negedge clk);
      checkOutput("reset lh_sop", 64'(lh_sop), 64'(0));
      checkOutput("reset lh_eop", 64'(lh_eop), 64'(0));
      checkAll();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      irl_lh_hdr_data  = '0;
      irl_lh_meta_data = '0;
      applyReset();

      // Single 4-beat packet straight through.
      sendPkt(4, 1'b1);
      idle(6, 1'b1);
      checkOutput("t1 pkt_in", 64'(stat_pkt_in), 64'(1));

      // 70 one-beat packets into a stalled output: meta FIFO limits to 16.
      applyReset();
      for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("t2 pkt_in", 64'(stat_pkt_in), 64'(16));
      checkOutput("t2 drop_ovf", 64'(stat_pkt_drop_ovf), 64'(54));
      idle(20, 1'b1);

      // 57 resident beats leave no room for a max-size packet.
      applyReset();
      for (int i = 0; i < 7; i++) sendPkt(8, 1'b0);
      sendPkt(1, 1'b0);
      sendPkt(2, 1'b0);
      checkOutput("t3 drop_ovf", 64'(stat_pkt_drop_ovf), 64'(1));
      idle(1, 1'b1);
      sendPkt(2, 1'b0);
      checkOutput("t3 pkt_in", 64'(stat_pkt_in), 64'(9));
      idle(70, 1'b1);

      // Over-length packet then a good one.
      applyReset();
      sendPkt(10, 1'b1);
      sendPkt(3, 1'b1);
      idle(5, 1'b1);
      checkOutput("t4 drop_err", 64'(stat_pkt_drop_err), 64'(1));
      checkOutput("t4 pkt_in", 64'(stat_pkt_in), 64'(1));

      // Missing eop, then an orphan middle beat.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("t5 drop_err", 64'(stat_pkt_drop_err), 64'(2));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      idle(4, 1'b1);
      checkOutput("t5 orphan drop_err", 64'(stat_pkt_drop_err), 64'(3));

      // Reset in the middle of a packet with committed data buffered.
      for (int i = 0; i < 3; i++) sendPkt(2, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyReset();
      sendPkt(3, 1'b1);
      idle(5, 1'b1);

      // Random traffic with phases of varying backpressure.
      for (int blk = 0; blk < 8; blk++) begin
         int rdyPct;
         rdyPct = $urandom_range(10, 100);
         for (int i = 0; i < 500; i++)
            applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 22,
                          $urandom_range(0, 99) < 28, $urandom_range(0, 99) < rdyPct);
      end
      idle(80, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end
endmodule
